udp_tx_scheduler: RTL and testbench

- Arbitrates between NUM_PORTS packet sources, e.g. the port-0 response path, port-1 C&C status and the DDC/mic data streams, for the single UDP transmit sender.
- Sequences each packet as a send / busy handshake to the sender.
- Presents the winning port's ID, payload length and per-port 32-bit sequence number.
- Acknowledges the requester when its packet completes.
- Sits between the per-port packet producers and the sender, in the Ethernet clock domain.

---
 rtl/udp_tx_pkg.sv | 34 +++
 rtl/udp_rr_arbiter.sv | 45 ++++
 rtl/udp_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP transmit scheduler.
package udp_tx_pkg;

    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned PORT_W    = 4;
    localparam int unsigned MAX_PORTS = 16;
    localparam int unsigned MAX_LEN_W = 32;
    localparam int unsigned LEN_BUS_W = MAX_PORTS * MAX_LEN_W;

    localparam logic [PORT_W-1:0] PORT_RESPONSE = 4'd0;
    localparam logic [PORT_W-1:0] PORT_CC       = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    // Extract port's len_w-bit field from a zero-extended flat length bus.
    function automatic logic [MAX_LEN_W-1:0] len_slice(
        input logic [LEN_BUS_W-1:0] bus,
        input logic [PORT_W-1:0]    port,
        input int unsigned          len_w
    );
        logic [LEN_BUS_W-1:0] shifted;
        logic [MAX_LEN_W-1:0] mask;
        shifted = bus >> (32'(port) * len_w);
        mask    = (len_w >= MAX_LEN_W) ? '1 : MAX_LEN_W'((64'd1 << len_w) - 64'd1);
        return shifted[MAX_LEN_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/udp_rr_arbiter.sv
// Port 0 wins outright; ports 1..N-1 share round-robin starting after rr_ptr.
module udp_rr_arbiter
    import udp_tx_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    rr_ptr,
    output logic [PORT_W-1:0]    winner_c,
    output logic                 valid_c
);

    logic [MAX_PORTS-1:0] req_all;
    logic [PORT_W:0]      start;
    logic [PORT_W:0]      cand;

    assign req_all = MAX_PORTS'(req);

    always_comb begin
        winner_c = PORT_RESPONSE;
        valid_c  = 1'b0;
        start    = {1'b0, rr_ptr} + 5'd1;
        if (start >= 5'(NUM_PORTS)) begin
            start = {1'b0, PORT_CC};
        end
        cand = start;
        if (req_all[PORT_RESPONSE]) begin
            winner_c = PORT_RESPONSE;
            valid_c  = 1'b1;
        end else begin
            // Walk ports 1..N-1 upward from start, wrapping back to port 1.
            for (int unsigned k = 0; k < NUM_PORTS - 1; k++) begin
                if (!valid_c && req_all[cand[PORT_W-1:0]]) begin
                    winner_c = cand[PORT_W-1:0];
                    valid_c  = 1'b1;
                end
                cand = cand + 5'd1;
                if (cand >= 5'(NUM_PORTS)) begin
                    cand = {1'b0, PORT_CC};
                end
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Arbitrates packet sources onto the single UDP sender with a send/busy handshake.
// Define UDP_TX_SCHED_TIMEOUT_EN to abort stalled handshakes after TIMEOUT_CYC cycles.
module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned LEN_W       = 16
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS*LEN_W-1:0] req_length,
    output logic [NUM_PORTS-1:0]       done,
    output logic [NUM_PORTS-1:0]       grant,
    output logic                       send,
    output logic [PORT_W-1:0]          port_ID,
    output logic [LEN_W-1:0]           udp_tx_length,
    output logic [SEQ_W-1:0]           sequence_number,
    input  logic                       sender_busy,
    output logic                       timeout_err
);

    state_t               state;
    logic [PORT_W-1:0]    rr_ptr;
    logic [SEQ_W-1:0]     seq [MAX_PORTS];
    logic [PORT_W-1:0]    pick;
    logic                 pick_valid;
    logic [LEN_BUS_W-1:0] len_bus;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC - 1);
    logic [31:0] tmo_cnt;
    logic        aborted;
`else
    assign timeout_err = 1'b0;
`endif

    assign len_bus = LEN_BUS_W'(req_length);

    udp_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .winner_c (pick),
        .valid_c  (pick_valid)
    );

    // Packet sequencer; port_ID doubles as the latched winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            for (int i = 0; i < MAX_PORTS; i++) begin
                seq[i] <= '0;
            end
            grant           <= '0;
            done            <= '0;
            send            <= 1'b0;
            port_ID         <= '0;
            udp_tx_length   <= '0;
            sequence_number <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
            tmo_cnt         <= '0;
            aborted         <= 1'b0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= '0;
                    if (pick_valid && !sender_busy) begin
                        port_ID         <= pick;
                        udp_tx_length   <= LEN_W'(len_slice(len_bus, pick, LEN_W));
                        sequence_number <= seq[pick];
                        grant           <= NUM_PORTS'(1) << pick;
                        state           <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    send  <= 1'b1;
                    state <= ST_ISSUE;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    tmo_cnt <= TMO_LOAD;
`endif
                end
                ST_ISSUE: begin
                    // Drop send as soon as busy is seen so the sender cannot re-launch.
                    if (sender_busy) begin
                        send  <= 1'b0;
                        state <= ST_ACTIVE;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                        tmo_cnt <= TMO_LOAD;
                    end else if (tmo_cnt == '0) begin
                        send        <= 1'b0;
                        timeout_err <= 1'b1;
                        aborted     <= 1'b1;
                        grant       <= '0;
                        done        <= NUM_PORTS'(1) << port_ID;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
`endif
                    end
                end
                ST_ACTIVE: begin
                    if (!sender_busy) begin
                        grant <= '0;
                        done  <= NUM_PORTS'(1) << port_ID;
                        state <= ST_DONE;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    end else if (tmo_cnt == '0) begin
                        timeout_err <= 1'b1;
                        aborted     <= 1'b1;
                        grant       <= '0;
                        done        <= NUM_PORTS'(1) << port_ID;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
`endif
                    end
                end
                ST_DONE: begin
                    done <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    aborted <= 1'b0;
                    if (!aborted)
`endif
                    seq[port_ID] <= seq[port_ID] + 32'd1;
                    if (port_ID != PORT_RESPONSE) begin
                        rr_ptr <= port_ID;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler (default build, timeout feature off).
module tb_udp_tx_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_length;
    logic [3:0]  done;
    logic [3:0]  grant;
    logic        send;
    logic [3:0]  port_ID;
    logic [15:0] udp_tx_length;
    logic [31:0] sequence_number;
    logic        sender_busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    udp_tx_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_length      (req_length),
        .done            (done),
        .grant           (grant),
        .send            (send),
        .port_ID         (port_ID),
        .udp_tx_length   (udp_tx_length),
        .sequence_number (sequence_number),
        .sender_busy     (sender_busy),
        .timeout_err     (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int p, input logic [15:0] v);
        req_length[p*16 +: 16] = v;
    endtask

    // Acts as the sender for one packet and checks the whole handshake.
    task automatic serve(input logic [3:0] p, input logic [15:0] len, input logic [31:0] sq,
                         input int hold, input logic [3:0] drop_mask);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << p;
        n  = 0;
        while (grant === 4'b0000 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("grant", 32'(grant), 32'(oh));
        chk("port_ID", 32'(port_ID), 32'(p));
        chk("length", 32'(udp_tx_length), 32'(len));
        chk("seqnum", sequence_number, sq);
        chk("send_pre", 32'(send), 32'd0);
        @(negedge clock);
        chk("send_rise", 32'(send), 32'd1);
        @(negedge clock);
        chk("send_hold", 32'(send), 32'd1);
        sender_busy = 1'b1;
        @(negedge clock);
        chk("send_drop", 32'(send), 32'd0);
        repeat (hold - 1) @(negedge clock);
        chk("done_early", 32'(done), 32'd0);
        sender_busy = 1'b0;
        @(negedge clock);
        chk("done", 32'(done), 32'(oh));
        chk("grant_clr", 32'(grant), 32'd0);
        req = req & ~drop_mask;
        @(negedge clock);
        chk("done_end", 32'(done), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req         = 4'b0000;
        req_length  = '0;
        sender_busy = 1'b0;
        set_len(0, 16'd64);
        set_len(1, 16'd300);
        set_len(2, 16'd1444);
        set_len(3, 16'd512);

        @(negedge clock);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_send", 32'(send), 32'd0);
        chk("rst_port", 32'(port_ID), 32'd0);
        chk("rst_len", 32'(udp_tx_length), 32'd0);
        chk("rst_seq", sequence_number, 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single request, then a repeat from the same port.
        req = 4'b0100;
        serve(4'd2, 16'd1444, 32'd0, 20, 4'b0100);
        req = 4'b0100;
        serve(4'd2, 16'd1444, 32'd1, 3, 4'b0100);

        // Reset while the packet is in flight.
        req = 4'b0010;
        for (int n = 0; n < 50 && send !== 1'b1; n++) @(negedge clock);
        chk("mid_send", 32'(send), 32'd1);
        @(negedge clock);
        sender_busy = 1'b1;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_port", 32'(port_ID), 32'd0);
        chk("mid_len", 32'(udp_tx_length), 32'd0);
        chk("mid_seq", sequence_number, 32'd0);
        req         = 4'b0000;
        sender_busy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        req = 4'b1000;
        serve(4'd3, 16'd512, 32'd0, 3, 4'b1000);

        // Port 0 dominates, then 1..3 rotate.
        req = 4'b1111;
        serve(4'd0, 16'd64, 32'd0, 3, 4'b0000);
        serve(4'd0, 16'd64, 32'd1, 3, 4'b0000);
        serve(4'd0, 16'd64, 32'd2, 3, 4'b0001);
        serve(4'd1, 16'd300, 32'd0, 3, 4'b0000);
        serve(4'd2, 16'd1444, 32'd0, 3, 4'b0000);
        serve(4'd3, 16'd512, 32'd1, 3, 4'b0000);
        serve(4'd1, 16'd300, 32'd1, 3, 4'b0000);
        serve(4'd2, 16'd1444, 32'd1, 3, 4'b0000);
        serve(4'd3, 16'd512, 32'd2, 3, 4'b1110);

        // Sequence wrap on port 3; port 1 keeps its own count.
        dut.seq[3] = 32'hFFFF_FFFF;
        req = 4'b1000;
        serve(4'd3, 16'd512, 32'hFFFF_FFFF, 3, 4'b0000);
        serve(4'd3, 16'd512, 32'h0000_0000, 3, 4'b1000);
        req = 4'b0010;
        serve(4'd1, 16'd300, 32'd2, 3, 4'b0010);

        // No grant while the sender is busy.
        sender_busy = 1'b1;
        req = 4'b0100;
        repeat (5) @(negedge clock);
        chk("busy_nogrant", 32'(grant), 32'd0);
        chk("busy_nosend", 32'(send), 32'd0);
        sender_busy = 1'b0;
        @(negedge clock);
        chk("busy_grant", 32'(grant), 32'b0100);
        serve(4'd2, 16'd1444, 32'd2, 3, 4'b0100);

        // Zero-length packet still goes out.
        set_len(1, 16'd0);
        req = 4'b0010;
        serve(4'd1, 16'd0, 32'd3, 3, 4'b0010);

        chk("tmo_off", 32'(timeout_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
